// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, serial shift, parallel load, rotate, clear and
// invert, selected by Mode and gated by En, with a synchronous active-high reset.
module univ_shift_reg #(
  parameter int                 WIDTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             SinR,
  input  logic             SinL,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qb,
  output logic             SoutR,
  output logic             SoutL
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHR   = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_LOAD  = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_ROL   = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_INV   = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (En) begin
      case (mode_e'(Mode))
        MODE_HOLD:  q_d = q_q;
        MODE_SHR:   q_d = {SinR, q_q[WIDTH-1:1]};
        MODE_SHL:   q_d = {q_q[WIDTH-2:0], SinL};
        MODE_LOAD:  q_d = D;
        MODE_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
        MODE_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        MODE_CLEAR: q_d = '0;
        MODE_INV:   q_d = ~q_q;
        default:    q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  // Complement and serial taps are combinational so they track Q with no lag,
  // which lets SoutR feed a neighbour's SinR for a seamless chained shifter.
  assign Q     = q_q;
  assign Qb    = ~q_q;
  assign SoutR = q_q[0];
  assign SoutL = q_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=4, RESET_VAL=0) with immediate
// assertions against hand-computed values.
module tb_univ_shift_reg;

  logic       Clk;
  logic       Rst;
  logic       En;
  logic [2:0] Mode;
  logic [3:0] D;
  logic       SinR;
  logic       SinL;
  logic [3:0] Q;
  logic [3:0] Qb;
  logic       SoutR;
  logic       SoutL;

  int checks;
  int failures;

  univ_shift_reg #(.WIDTH(4), .RESET_VAL(4'b0000)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .En    (En),
    .Mode  (Mode),
    .D     (D),
    .SinR  (SinR),
    .SinL  (SinL),
    .Q     (Q),
    .Qb    (Qb),
    .SoutR (SoutR),
    .SoutL (SoutL)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic [3:0] exp);
    chk({tag, ".Q"}, Q, exp);
    chk({tag, ".Qb"}, Qb, ~exp);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Rst  = 1'b1;
    En   = 1'b0;
    Mode = 3'b000;
    D    = 4'b0000;
    SinR = 1'b0;
    SinL = 1'b0;
    step();
    chk_q("init_reset", 4'b0000);

    // Establish Q=1010, then reset with a competing load pending
    Rst = 1'b0; En = 1'b1; Mode = 3'b011; D = 4'b1010;
    step();
    chk_q("preload_1010", 4'b1010);
    Rst = 1'b1; En = 1'b1; Mode = 3'b011; D = 4'b1111;
    step();
    chk_q("reset_over_load", 4'b0000);

    // Load then hold with En=0
    Rst = 1'b0; Mode = 3'b011; D = 4'b1011;
    step();
    chk_q("load_1011", 4'b1011);
    En = 1'b0; Mode = 3'b111; D = 4'b0000; SinR = 1'b1; SinL = 1'b1;
    step();
    chk_q("hold_en0_1", 4'b1011);
    step();
    chk_q("hold_en0_2", 4'b1011);
    step();
    chk_q("hold_en0_3", 4'b1011);

    // Mode 000 hold with enable
    En = 1'b1; Mode = 3'b000;
    step();
    chk_q("hold_mode0", 4'b1011);

    // Shift right
    Mode = 3'b001; SinR = 1'b0;
    chk("shr_soutr_1", {3'b000, SoutR}, 4'b0001);
    step();
    chk_q("shr_1", 4'b0101);
    SinR = 1'b1;
    chk("shr_soutr_2", {3'b000, SoutR}, 4'b0001);
    step();
    chk_q("shr_2", 4'b1010);

    // Shift left
    Mode = 3'b011; D = 4'b1011;
    step();
    Mode = 3'b010; SinL = 1'b1;
    chk("shl_soutl", {3'b000, SoutL}, 4'b0001);
    step();
    chk_q("shl_1", 4'b0111);

    // Rotate right four times returns to start, then rotate left once
    Mode = 3'b011; D = 4'b1000;
    step();
    Mode = 3'b100;
    step();
    chk_q("ror_1", 4'b0100);
    step();
    chk_q("ror_2", 4'b0010);
    step();
    chk_q("ror_3", 4'b0001);
    step();
    chk_q("ror_4", 4'b1000);
    Mode = 3'b101;
    step();
    chk_q("rol_1", 4'b0001);

    // Invert and clear
    Mode = 3'b011; D = 4'b0110;
    step();
    Mode = 3'b111;
    step();
    chk_q("invert", 4'b1001);
    Mode = 3'b110;
    step();
    chk_q("clear", 4'b0000);

    // Input changes between edges must not disturb Q, including a Rst pulse
    Mode = 3'b011; D = 4'b1100;
    step();
    chk_q("load_1100", 4'b1100);
    Mode = 3'b000; Rst = 1'b1; D = 4'b0011;
    #2;
    chk_q("rst_between_edges", 4'b1100);
    Rst = 1'b0;
    step();
    chk_q("after_rst_glitch", 4'b1100);

    // Shift-right run aborted by reset on the second edge, then resumed
    Mode = 3'b001; SinR = 1'b0;
    step();
    chk_q("run_shr_1", 4'b0110);
    Rst = 1'b1;
    step();
    chk_q("run_reset", 4'b0000);
    Rst = 1'b0; SinR = 1'b1;
    step();
    chk_q("run_resume_1", 4'b1000);
    SinR = 1'b0;
    step();
    chk_q("run_resume_2", 4'b0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the register width in bits; legal range 2..32.
REQ-002 The block SHALL have parameter RESET_VAL, default 0, giving the WIDTH-bit value loaded by reset.
REQ-003 The block SHALL have a single clock and a synchronous, active-high reset; all state SHALL update on the rising edge of Clk only.
REQ-004 Port: Clk  input  1  clock, rising-edge active.
REQ-005 Port: Rst  input  1  synchronous active-high reset.
REQ-006 Port: En  input  1  operation enable; 0 = hold regardless of Mode.
REQ-007 Port: Mode  input  3  operation select, per REQ-012.
REQ-008 Port: D  input  WIDTH  parallel load data.
REQ-009 Port: SinR  input  1  serial input entering at the MSB on shift right.
REQ-010 Port: SinL  input  1  serial input entering at the LSB on shift left.
REQ-011 Ports: Q output WIDTH register state; Qb output WIDTH bitwise complement of Q; SoutR output 1 = Q[0]; SoutL output 1 = Q[WIDTH-1].

Function
REQ-012 On a rising Clk edge with Rst=0 and En=1, Q SHALL take the next value selected by Mode:
- 000 hold: Q unchanged.
- 001 shift right: Q = {SinR, Q[WIDTH-1:1]}.
- 010 shift left: Q = {Q[WIDTH-2:0], SinL}.
- 011 parallel load: Q = D.
- 100 rotate right: Q = {Q[0], Q[WIDTH-1:1]}.
- 101 rotate left: Q = {Q[WIDTH-2:0], Q[WIDTH-1]}.
- 110 clear: Q = all zeros (independent of RESET_VAL).
- 111 invert: Q = ~Q.
REQ-013 With Rst=0 and En=0, Q SHALL hold its value irrespective of Mode, D, SinR, SinL.
REQ-014 Latency SHALL be exactly one rising Clk edge from sampled inputs to the new Q; inputs SHALL be sampled only at the rising edge, and input changes between edges SHALL NOT affect Q.
REQ-015 Qb SHALL equal ~Q at all times, including during and after reset; there SHALL be no cycle in which Qb == Q for any bit.
REQ-016 SoutR and SoutL SHALL be combinational taps of Q, so the bit shifted out is visible on the tap during the cycle before the shift edge.
REQ-017 Chaining: SoutR of one instance driving SinR of another SHALL form a 2*WIDTH-bit right shifter with no extra delay.
REQ-018 Rotate modes SHALL be lossless: WIDTH consecutive rotates in one direction SHALL return Q to its starting value.
REQ-019 No X SHALL propagate from Mode values; all 8 encodings are defined.

Reset
REQ-020 When Rst=1 at a rising Clk edge, Q SHALL become RESET_VAL and Qb ~RESET_VAL, regardless of En and Mode.
REQ-021 Rst SHALL take priority over all other inputs; Rst asserted mid-sequence (e.g. during a shift run) SHALL abort it and the next enabled edge after deassertion SHALL operate from RESET_VAL.
REQ-022 Rst asserted between edges SHALL have no effect until the next rising edge.
REQ-023 Before the first reset edge Q is undefined; benches SHALL apply Rst for at least one edge.

Verification (WIDTH=4, RESET_VAL=0, Clk period 10)
REQ-024 Reset: Q=1010, Rst=1 for one edge with En=1, Mode=011, D=1111 -> Q=0000, Qb=1111.
REQ-025 Load then hold: En=1, Mode=011, D=1011, one edge -> Q=1011, Qb=0100; then En=0, Mode=111 for 3 edges -> Q stays 1011.
REQ-026 Shift right: Q=1011, Mode=001, SinR=0 then 1 over two edges -> Q=0101 then 1010; SoutR was 1 then 1 before each edge.
REQ-027 Shift left: Q=1011, Mode=010, SinL=1 -> Q=0111, SoutL was 1 before the edge.
REQ-028 Rotate: Q=1000, Mode=100 for 4 edges -> 0100, 0010, 0001, 1000; Mode=101 once from 1000 -> 0001.
REQ-029 Clear/invert/mid-op reset: Q=0110, Mode=111 -> 1001; Mode=110 -> 0000; shift-right run with Rst=1 on 2nd edge -> Q=0000 on that edge, shifting resumes from 0000 after Rst=0.
